// File: rtl/alu_seq_core.sv
// Clocked ALU: one instruction per handshake, registered result/NZCV flags,
// iterative shift-add MUL, internal program counter.
module alu_seq_core #(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 8,
  parameter int SHIFT_STEP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        cond,
  input  logic [3:0]        opcode,
  input  logic              s,
  input  logic [2:0]        shift,
  input  logic [15:0]       immediate_value,
  input  logic [DATA_W-1:0] source1,
  input  logic [DATA_W-1:0] source2,
  output logic [DATA_W-1:0] result,
  output logic              out_wr,
  output logic              out_valid,
  output logic [3:0]        flags,
  output logic              busy,
  output logic [PC_W-1:0]   pc_out
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_ORR  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_MOVI = 4'd6;
  localparam logic [3:0] OP_MOV  = 4'd7;
  localparam logic [3:0] OP_CMP  = 4'd8;
  localparam int         CNT_W   = $clog2(DATA_W + 1);

  typedef enum logic [0:0] {IDLE, MUL_RUN} state_t;

  state_t              state, state_nxt;
  logic                accept;
  logic [31:0]         shamt;
  logic [DATA_W-1:0]   op_b;
  logic [DATA_W:0]     add_full, sub_full;
  logic                add_v, sub_v;
  logic [3:0]          cmp_flags;
  logic                pred;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_wr;
  logic [3:0]          alu_flags;
  logic                start_mul;
  logic [CNT_W-1:0]    mul_cnt;
  logic [DATA_W-1:0]   mul_acc, mul_mcand, mul_mplier, mul_step;
  logic                mul_s, mul_last;

  // flags layout {n,z,c,v}
  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:    return 1'b1;
      4'd1:    return z;
      4'd2:    return !z && (n == v);
      4'd3:    return n != v;
      4'd4:    return !z;
      4'd5:    return n == v;
      4'd6:    return cf && !z;
      4'd7:    return !cf || z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] nz_flags(input logic [DATA_W-1:0] r, input logic [3:0] f);
    return {r[DATA_W-1], r == '0, f[1], f[0]};
  endfunction

  assign accept = in_valid && in_ready;
  assign shamt  = 32'(shift) * SHIFT_STEP;
  assign op_b   = (shamt >= 32'(DATA_W)) ? '0 : (source2 >> shamt);

  // SUB as A + ~B + 1 so the carry out is directly NOT borrow
  assign add_full = {1'b0, source1} + {1'b0, op_b};
  assign sub_full = {1'b0, source1} + {1'b0, ~op_b} + {{DATA_W{1'b0}}, 1'b1};
  assign add_v = (source1[DATA_W-1] == op_b[DATA_W-1]) &&
                 (add_full[DATA_W-1] != source1[DATA_W-1]);
  assign sub_v = (source1[DATA_W-1] != op_b[DATA_W-1]) &&
                 (sub_full[DATA_W-1] != source1[DATA_W-1]);
  assign cmp_flags = {sub_full[DATA_W-1], sub_full[DATA_W-1:0] == '0,
                      sub_full[DATA_W], sub_v};
  assign pred = cond_true(cond, flags);

  always_comb begin
    alu_res   = result;
    alu_wr    = 1'b0;
    alu_flags = flags;
    start_mul = 1'b0;
    if (opcode == OP_CMP) begin
      alu_flags = cmp_flags;
      alu_res   = cond_true(cond, cmp_flags) ? DATA_W'(1) : '0;
      alu_wr    = 1'b1;
    end else if (pred) begin
      case (opcode)
        OP_ADD: begin
          alu_res = add_full[DATA_W-1:0];
          alu_wr  = 1'b1;
          if (s) alu_flags = {add_full[DATA_W-1], add_full[DATA_W-1:0] == '0,
                              add_full[DATA_W], add_v};
        end
        OP_SUB: begin
          alu_res = sub_full[DATA_W-1:0];
          alu_wr  = 1'b1;
          if (s) alu_flags = cmp_flags;
        end
        OP_MUL:  start_mul = 1'b1;
        OP_ORR:  begin alu_res = source1 | op_b;  alu_wr = 1'b1; end
        OP_AND:  begin alu_res = source1 & op_b;  alu_wr = 1'b1; end
        OP_XOR:  begin alu_res = source1 ^ op_b;  alu_wr = 1'b1; end
        OP_MOVI: begin alu_res = DATA_W'(immediate_value); alu_wr = 1'b1; end
        OP_MOV:  begin alu_res = op_b;            alu_wr = 1'b1; end
        default: ;
      endcase
      if (s && opcode >= OP_ORR && opcode <= OP_MOV) alu_flags = nz_flags(alu_res, flags);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  assign mul_last = (state == MUL_RUN) && (mul_cnt == CNT_W'(DATA_W - 1));
  assign mul_step = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    in_ready  = 1'b1;
    case (state)
      IDLE:    if (accept && start_mul) state_nxt = MUL_RUN;
      MUL_RUN: begin
        busy     = 1'b1;
        in_ready = 1'b0;
        if (mul_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result     <= '0;
      flags      <= '0;
      pc_out     <= '0;
      out_valid  <= 1'b0;
      out_wr     <= 1'b0;
      mul_cnt    <= '0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_s      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_wr    <= 1'b0;
      if (accept) begin
        pc_out <= pc_out + PC_W'(1);
        if (start_mul) begin
          mul_acc    <= '0;
          mul_mcand  <= source1;
          mul_mplier <= op_b;
          mul_cnt    <= '0;
          mul_s      <= s;
        end else begin
          out_valid <= 1'b1;
          out_wr    <= alu_wr;
          result    <= alu_res;
          flags     <= alu_flags;
        end
      end
      if (state == MUL_RUN) begin
        mul_acc    <= mul_step;
        mul_mcand  <= mul_mcand << 1;
        mul_mplier <= mul_mplier >> 1;
        mul_cnt    <= mul_cnt + CNT_W'(1);
        if (mul_last) begin
          out_valid <= 1'b1;
          out_wr    <= 1'b1;
          result    <= mul_step;
          if (mul_s) flags <= nz_flags(mul_step, flags);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core with a retire scoreboard.
module tb_alu_seq_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  cond;
  logic [3:0]  opcode;
  logic        s;
  logic [2:0]  shift;
  logic [15:0] immediate_value;
  logic [31:0] source1;
  logic [31:0] source2;
  logic [31:0] result;
  logic        out_wr;
  logic        out_valid;
  logic [3:0]  flags;
  logic        busy;
  logic [7:0]  pc_out;

  typedef struct {
    logic [31:0] res;
    logic        wr;
    logic [3:0]  fl;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         last_ret = 0;
  int         acc_cyc = 0;
  logic [7:0] exp_pc = 8'd0;

  alu_seq_core #(.DATA_W(32), .PC_W(8), .SHIFT_STEP(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .opcode(opcode), .s(s), .shift(shift),
    .immediate_value(immediate_value), .source1(source1), .source2(source2),
    .result(result), .out_wr(out_wr), .out_valid(out_valid), .flags(flags),
    .busy(busy), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock, sample 1ns later, score any retirement.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid === 1'b1) begin
      last_ret = cyc;
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_retire observed=%0h expected=none", result);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("result", 64'(result), 64'(e.res));
        chk("out_wr", 64'(out_wr), 64'(e.wr));
        chk("flags", 64'(flags), 64'(e.fl));
      end
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] cd, input logic s_i,
                       input logic [2:0] sh, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] imm, input logic push,
                       input logic [31:0] e_res, input logic e_wr, input logic [3:0] e_fl);
    exp_t e;
    opcode = op; cond = cd; s = s_i; shift = sh;
    source1 = a; source2 = b; immediate_value = imm;
    in_valid = 1'b1;
    if (push) begin
      e.res = e_res; e.wr = e_wr; e.fl = e_fl;
      sb.push_back(e);
    end
    exp_pc = exp_pc + 8'd1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; cond = 4'd0; opcode = 4'd0; s = 1'b0;
    shift = 3'd0; immediate_value = 16'd0; source1 = '0; source2 = '0;
    tick(); tick();
    chk("rst_result", 64'(result), 64'h0);
    chk("rst_flags", 64'(flags), 64'h0);
    chk("rst_pc", 64'(pc_out), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_wr", 64'(out_wr), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    reset = 1'b0;
    tick();

    // ADD without flag update
    acc_cyc = cyc + 1;
    issue(4'd0, 4'd0, 1'b0, 3'd0, 32'd1, 32'd2, 16'd0, 1'b1, 32'h3, 1'b1, 4'b0000);
    chk("add_latency", 64'(last_ret), 64'(acc_cyc));
    chk("pc_after_add", 64'(pc_out), 64'(exp_pc));

    issue(4'd1, 4'd0, 1'b1, 3'd0, 32'h1111, 32'h1111, 16'd0, 1'b1, 32'h0, 1'b1, 4'b0110);
    issue(4'd1, 4'd0, 1'b1, 3'd0, 32'h0, 32'hFFFF, 16'd0, 1'b1, 32'hFFFF0001, 1'b1, 4'b1000);
    // shift=1 pushes 0x6 fully out
    issue(4'd3, 4'd0, 1'b1, 3'd1, 32'h9, 32'h6, 16'd0, 1'b1, 32'h9, 1'b1, 4'b0000);
    chk("pc_after_orr", 64'(pc_out), 64'(exp_pc));

    // MUL: 32 busy cycles with an ignored offer, retire on the 32nd edge after accept
    issue(4'd2, 4'd0, 1'b0, 3'd0, 32'd5, 32'h23, 16'd0, 1'b1, 32'hAF, 1'b1, 4'b0000);
    acc_cyc = cyc;
    opcode = 4'd0; source1 = 32'd7; source2 = 32'd9; in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("mul_busy", 64'(busy), 64'h1);
      chk("mul_in_ready", 64'(in_ready), 64'h0);
      if (i == 31) in_valid = 1'b0;
      tick();
    end
    chk("mul_retire_cycle", 64'(last_ret - acc_cyc), 64'd32);
    chk("mul_busy_done", 64'(busy), 64'h0);
    chk("pc_after_mul", 64'(pc_out), 64'(exp_pc));

    issue(4'd1, 4'd0, 1'b1, 3'd0, 32'h1111, 32'h1111, 16'd0, 1'b1, 32'h0, 1'b1, 4'b0110);
    // NE fails with z=1: retire without write, result held
    issue(4'd0, 4'd4, 1'b1, 3'd0, 32'h1, 32'h1, 16'd0, 1'b1, 32'h0, 1'b0, 4'b0110);
    issue(4'd8, 4'd6, 1'b0, 3'd0, 32'h11111, 32'h1111, 16'd0, 1'b1, 32'h1, 1'b1, 4'b0010);
    // MOVI touches only n,z; c stays set
    issue(4'd6, 4'd0, 1'b1, 3'd0, 32'h0, 32'h0, 16'hFFFF, 1'b1, 32'hFFFF, 1'b1, 4'b0010);
    issue(4'd7, 4'd8, 1'b1, 3'd0, 32'h0, 32'h5, 16'd0, 1'b1, 32'hFFFF, 1'b0, 4'b0010);
    issue(4'd9, 4'd0, 1'b1, 3'd0, 32'h3, 32'h4, 16'd0, 1'b1, 32'hFFFF, 1'b0, 4'b0010);
    chk("pc_after_ldr", 64'(pc_out), 64'(exp_pc));

    // Reset in the middle of a MUL: no retirement may follow
    issue(4'd2, 4'd0, 1'b1, 3'd0, 32'd3, 32'd3, 16'd0, 1'b0, 32'h0, 1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) tick();
    chk("mid_mul_busy", 64'(busy), 64'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_pc = 8'd0;
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_in_ready", 64'(in_ready), 64'h1);
    chk("abort_pc", 64'(pc_out), 64'(exp_pc));
    chk("abort_flags", 64'(flags), 64'h0);
    chk("abort_out_valid", 64'(out_valid), 64'h0);
    for (int i = 0; i < 40; i++) tick();

    for (int i = 0; i < 256; i++) begin
      issue(4'd10, 4'd0, 1'b0, 3'd0, 32'h0, 32'h0, 16'd0, 1'b1, 32'h0, 1'b0, 4'b0000);
      if (i == 254) chk("pc_max", 64'(pc_out), 64'hFF);
    end
    chk("pc_wrap", 64'(pc_out), 64'(exp_pc));
    tick();
    chk("sb_drained", 64'(sb.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
